// File: rtl/udp_rx_sched.sv
// Receive-side scheduler for the UDP buffer-to-FIFO copier: validates length,
// waits for FIFO space, runs the fs/fd handshake and returns the buffer to the MAC.
module udp_rx_sched #(
  parameter logic [15:0] MIN_LEN = 16'd9,
  parameter logic [15:0] MAX_LEN = 16'd1488,
  parameter logic [15:0] TIMEOUT = 16'd4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_done,
  input  logic [15:0] udp_rx_len,
  output logic        rx_release,
  input  logic [12:0] fifoc_free,
  output logic        fs,
  input  logic        fd,
  output logic        busy,
  output logic [15:0] pkt_cnt,
  output logic [15:0] drop_cnt,
  output logic        err_timeout
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_WAIT, S_COPY, S_REL} state_t;

  state_t      r_state, w_next;
  logic [15:0] r_len_q, r_pend_len, r_timer, r_pkt_cnt, r_drop_cnt;
  logic        r_pend_v, r_err;

  logic [15:0] w_pay;
  logic        w_space, w_len_bad, w_expire;
  logic        w_load_pend, w_pkt_inc, w_fsm_drop, w_set_err, w_timer_clr, w_timer_inc;
  logic        w_slot_take, w_slot_drop;
  logic [1:0]  w_drop_inc;

  function automatic logic [15:0] sat_add(input logic [15:0] v, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, v} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign w_pay     = r_len_q - 16'd8;
  assign w_space   = {3'b000, fifoc_free} >= w_pay;
  assign w_len_bad = (r_len_q < MIN_LEN) || (r_len_q > MAX_LEN);
  assign w_expire  = (r_timer == TIMEOUT - 16'd1);

  // A packet arriving while busy (or while the slot is being drained) goes to the slot;
  // the slot only overflows if it is still occupied after this cycle.
  assign w_slot_take = rx_done && ((r_state != S_IDLE) || r_pend_v);
  assign w_slot_drop = w_slot_take && r_pend_v && !w_load_pend;
  assign w_drop_inc  = {1'b0, w_fsm_drop} + {1'b0, w_slot_drop};

  always_comb begin
    w_next      = r_state;
    w_load_pend = 1'b0;
    w_pkt_inc   = 1'b0;
    w_fsm_drop  = 1'b0;
    w_set_err   = 1'b0;
    w_timer_clr = 1'b0;
    w_timer_inc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pend_v) begin
          w_load_pend = 1'b1;
          w_next      = S_CHECK;
        end else if (rx_done) begin
          w_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_len_bad) begin
          w_fsm_drop = 1'b1;
          w_next     = S_REL;
        end else begin
          w_timer_clr = 1'b1;
          w_next      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_space) begin
          w_timer_clr = 1'b1;
          w_next      = S_COPY;
        end else if (w_expire) begin
          w_fsm_drop = 1'b1;
          w_next     = S_REL;
        end else begin
          w_timer_inc = 1'b1;
        end
      end
      S_COPY: begin
        if (fd) begin
          w_pkt_inc = 1'b1;
          w_next    = S_REL;
        end else if (w_expire) begin
          w_set_err  = 1'b1;
          w_fsm_drop = 1'b1;
          w_next     = S_REL;
        end else begin
          w_timer_inc = 1'b1;
        end
      end
      S_REL: begin
        if (!fd) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_len_q    <= 16'd0;
      r_pend_v   <= 1'b0;
      r_pend_len <= 16'd0;
      r_timer    <= 16'd0;
      r_pkt_cnt  <= 16'd0;
      r_drop_cnt <= 16'd0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load_pend) r_len_q <= r_pend_len;
      else if (rx_done && (r_state == S_IDLE)) r_len_q <= udp_rx_len;
      if (w_slot_take && !w_slot_drop) begin
        r_pend_v   <= 1'b1;
        r_pend_len <= udp_rx_len;
      end else if (w_load_pend) begin
        r_pend_v <= 1'b0;
      end
      if (w_timer_clr) r_timer <= 16'd0;
      else if (w_timer_inc) r_timer <= r_timer + 16'd1;
      if (w_pkt_inc) r_pkt_cnt <= sat_add(r_pkt_cnt, 2'd1);
      if (w_drop_inc != 2'd0) r_drop_cnt <= sat_add(r_drop_cnt, w_drop_inc);
      if (w_set_err) r_err <= 1'b1;
    end
  end

  assign fs          = (r_state == S_COPY);
  assign busy        = (r_state != S_IDLE);
  assign rx_release  = (r_state == S_REL) && !fd;
  assign pkt_cnt     = r_pkt_cnt;
  assign drop_cnt    = r_drop_cnt;
  assign err_timeout = r_err;

endmodule
